tdm_demux_1x8: RTL and testbench

//  Receive-side time-division demultiplexer for the 8-channel TDM link fed by our
//  8:1 selector tree. Accepts one W-bit sample per enabled clock on a single lane.

---
 rtl/tdm_demux_1x8_if.sv | 36 +++
 rtl/tdm_demux_1x8.sv | 99 +++++++++
 tb/tb_tdm_demux_1x8.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/tdm_demux_1x8_if.sv
// Bundle of the TDM demultiplexer's serial input lane and parallel frame outputs.
//   en, sync, din      : serial side (driven by the link / master)
//   q0..q7             : slot k of the last complete frame
//   frame_valid        : 1-cycle pulse, q0..q7 just updated
//   locked             : aligned to the frame
//   sync_err           : 1-cycle pulse, sync seen away from slot 0 while locked
//   slot               : slot the next en-qualified sample will fill
interface tdm_demux_1x8_if #(
  parameter int unsigned W = 1
);
  logic         en;
  logic         sync;
  logic [W-1:0] din;
  logic [W-1:0] q0;
  logic [W-1:0] q1;
  logic [W-1:0] q2;
  logic [W-1:0] q3;
  logic [W-1:0] q4;
  logic [W-1:0] q5;
  logic [W-1:0] q6;
  logic [W-1:0] q7;
  logic         frame_valid;
  logic         locked;
  logic         sync_err;
  logic [2:0]   slot;

  modport master (
    output en, sync, din,
    input  q0, q1, q2, q3, q4, q5, q6, q7, frame_valid, locked, sync_err, slot
  );

  modport slave (
    input  en, sync, din,
    output q0, q1, q2, q3, q4, q5, q6, q7, frame_valid, locked, sync_err, slot
  );
endinterface

// File: rtl/tdm_demux_1x8.sv
// Receive-side 8-slot TDM demultiplexer. Aligns to the frame with an en-qualified
// sync strobe, collects slots 0..6 in shadow registers and, on the slot-7 sample,
// publishes the whole frame to q0..q7 in one edge (q7 taken straight from din).
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : tdm_demux_1x8_if slave (en/sync/din in; q0..q7, frame_valid, locked,
//          sync_err, slot out)
module tdm_demux_1x8 #(
  parameter int unsigned W = 1
) (
  input logic            clk,
  input logic            rst,
  tdm_demux_1x8_if.slave bus
);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e       state_q, state_d;
  logic [2:0]   slot_q, slot_d;
  logic [W-1:0] shadow_q [7];
  logic [W-1:0] shadow_d [7];
  logic [W-1:0] q_q [8];
  logic [W-1:0] q_d [8];
  logic         fv_q, fv_d;
  logic         err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StHunt;
      slot_q  <= 3'd0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int k = 0; k < 7; k++) shadow_q[k] <= '0;
      for (int k = 0; k < 8; k++) q_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      q_q      <= q_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    q_d      = q_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;

    if (bus.en) begin
      unique case (state_q)
        StHunt: begin
          if (bus.sync) begin
            shadow_d[0] = bus.din;
            slot_d      = 3'd1;
            state_d     = StLocked;
          end
        end
        StLocked: begin
          if (bus.sync && (slot_q != 3'd0)) begin
            // Resync: drop the partial frame and restart at slot 0 with this sample.
            shadow_d[0] = bus.din;
            slot_d      = 3'd1;
            err_d       = 1'b1;
          end else if (slot_q == 3'd7) begin
            for (int k = 0; k < 7; k++) q_d[k] = shadow_q[k];
            q_d[7] = bus.din;
            fv_d   = 1'b1;
            slot_d = 3'd0;
          end else begin
            for (int k = 0; k < 7; k++) begin
              if (slot_q == 3'(k)) shadow_d[k] = bus.din;
            end
            slot_d = slot_q + 3'd1;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  assign bus.q0          = q_q[0];
  assign bus.q1          = q_q[1];
  assign bus.q2          = q_q[2];
  assign bus.q3          = q_q[3];
  assign bus.q4          = q_q[4];
  assign bus.q5          = q_q[5];
  assign bus.q6          = q_q[6];
  assign bus.q7          = q_q[7];
  assign bus.frame_valid = fv_q;
  assign bus.sync_err    = err_q;
  assign bus.locked      = (state_q == StLocked);
  assign bus.slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Self-checking bench for tdm_demux_1x8 (W=4): directed steps followed by random
// traffic, all compared each cycle against a frame-level reference model.
module tb_tdm_demux_1x8;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdm_demux_1x8_if #(.W(W)) bus ();

  tdm_demux_1x8 #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a list of the samples of the frame being collected.
  logic [W-1:0]   part [$];
  bit             m_locked;
  logic [8*W-1:0] m_q;
  logic           m_fv;
  logic           m_err;

  function automatic logic [8*W-1:0] dut_q();
    return {bus.q7, bus.q6, bus.q5, bus.q4, bus.q3, bus.q2, bus.q1, bus.q0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"}, 64'(dut_q()), 64'(m_q));
    chk({tag, ".frame_valid"}, 64'(bus.frame_valid), 64'(m_fv));
    chk({tag, ".sync_err"}, 64'(bus.sync_err), 64'(m_err));
    chk({tag, ".locked"}, 64'(bus.locked), 64'(m_locked));
    chk({tag, ".slot"}, 64'(bus.slot), 64'(part.size()));
    // The two pulses are mutually exclusive.
    chk({tag, ".pulse_excl"}, 64'(bus.frame_valid & bus.sync_err), 64'd0);
  endtask

  task automatic model_reset();
    part.delete();
    m_locked = 1'b0;
    m_q      = '0;
    m_fv     = 1'b0;
    m_err    = 1'b0;
  endtask

  // One clock: drive inputs, advance the model by the same sample, check #1 after the edge.
  task automatic step(input string tag, input logic e, input logic s, input logic [W-1:0] d);
    bus.en   = e;
    bus.sync = s;
    bus.din  = d;
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (e) begin
      if (!m_locked) begin
        if (s) begin
          part.delete();
          part.push_back(d);
          m_locked = 1'b1;
        end
      end else if (s && part.size() != 0) begin
        part.delete();
        part.push_back(d);
        m_err = 1'b1;
      end else begin
        part.push_back(d);
        if (part.size() == 8) begin
          for (int k = 0; k < 8; k++) m_q[k*W +: W] = part[k];
          part.delete();
          m_fv = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    int fv_count;
    bus.en   = 1'b0;
    bus.sync = 1'b0;
    bus.din  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // 1: reset mid-frame, then unsynced samples are discarded.
    step("pre", 1'b1, 1'b1, 4'hA);
    step("pre", 1'b1, 1'b0, 4'hB);
    step("pre", 1'b1, 1'b0, 4'hC);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("hunt", 1'b1, 1'b0, 4'(i + 5));

    // 2: basic frame 1..8.
    for (int i = 0; i < 8; i++) step("basic", 1'b1, (i == 0), 4'(i + 1));
    chk("basic.q_value", 64'(dut_q()), 64'h87654321);
    step("basic_idle", 1'b0, 1'b1, 4'hF);

    // 3: same frame with en=0 gaps; sync lands at slot 0 (no error).
    fv_count = 0;
    for (int i = 0; i < 8; i++) begin
      step("gap", 1'b1, (i == 0), 4'(i + 1));
      if (bus.frame_valid) fv_count++;
      for (int g = 0; g < int'($urandom_range(3, 1)); g++) begin
        step("gap_idle", 1'b0, 1'($urandom), 4'($urandom));
        if (bus.frame_valid) fv_count++;
      end
    end
    chk("gap.fv_count", 64'(fv_count), 64'd1);

    // 4: flywheel, two frames, sync only on the first.
    fv_count = 0;
    for (int i = 0; i < 16; i++) begin
      step("fly", 1'b1, (i == 0), 4'($urandom));
      if (bus.frame_valid) fv_count++;
    end
    chk("fly.fv_count", 64'(fv_count), 64'd2);

    // 5: resync at slot 5, then 7 more samples finish a frame started at the sync sample.
    for (int i = 0; i < 5; i++) step("pre_resync", 1'b1, 1'b0, 4'($urandom));
    step("resync", 1'b1, 1'b1, 4'h9);
    chk("resync.slot", 64'(bus.slot), 64'd1);
    for (int i = 0; i < 7; i++) step("post_resync", 1'b1, 1'b0, 4'(i + 1));
    chk("resync.q0", 64'(bus.q0), 64'h9);

    // Random traffic, including rare syncs and en gaps.
    for (int i = 0; i < 600; i++) begin
      step("rand", 1'($urandom_range(9, 0) < 7), 1'($urandom_range(11, 0) == 0), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
